// File: rtl/aes_run_controller_pkg.sv
// Shared definitions for the AES run sequencer: FSM encoding and the status byte
// layout that firmware reads back from output memory offset 0x050.
package aes_run_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } run_state_t;

    localparam int STATUS_DONE_BIT    = 0;
    localparam int STATUS_TIMEOUT_BIT = 1;
    localparam int STATUS_BUSY_BIT    = 2;

    function automatic logic [7:0] status_byte(input logic done, input logic timeout,
                                               input logic busy);
        logic [7:0] s;
        s                     = '0;
        s[STATUS_DONE_BIT]    = done;
        s[STATUS_TIMEOUT_BIT] = timeout;
        s[STATUS_BUSY_BIT]    = busy;
        return s;
    endfunction

endpackage

// File: rtl/aes_run_controller_watchdog.sv
// Per-encryption watchdog: restarted on every core trigger, flags expiry after
// TIMEOUT_CYCLES cycles counted from the trigger cycle itself.
module aes_run_controller_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired,
    output logic first_cycle
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // The trigger cycle counts as cycle 0, so the first wait cycle sees a count of 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (run && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired     = (count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign first_cycle = (count == CNT_W'(1));

endmodule

// File: rtl/aes_run_controller.sv
// Sequencer between the USB register map and the AES core: runs 1..256 chained
// encryptions per host go edge, frames them with a scope trigger, reports status.
module aes_run_controller
    import aes_run_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TRIG_PRE       = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [7:0]   repeat_cnt,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plaintext,
    output logic         aes_trigger,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    output logic [127:0] ct_out,
    output logic [7:0]   runs_done,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         scope_trig
);

    run_state_t state, state_nxt;

    logic       go_q;
    logic [7:0] rep_q;
    logic [3:0] pre_cnt;
    logic       wd_expired;
    logic       wd_first;
    logic       go_edge;
    logic       done_seen;
    logic [8:0] runs_next;
    logic       last_run;

    assign go_edge     = go && !go_q;
    // The core may still show the previous result in the first wait cycle.
    assign done_seen   = aes_done && !wd_first;
    assign runs_next   = {1'b0, runs_done} + 9'd1;
    assign last_run    = (runs_next == ({1'b0, rep_q} + 9'd1));
    assign aes_trigger = (state == S_START);

    aes_run_controller_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .load       (state == S_START),
        .run        (state == S_WAIT),
        .expired    (wd_expired),
        .first_cycle(wd_first)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (go_edge) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (TRIG_PRE == 0) ? S_START : S_PRE;
            S_PRE:     if (pre_cnt == 4'(TRIG_PRE - 1)) state_nxt = S_START;
            S_START:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_seen)       state_nxt = S_CAPTURE;
                else if (wd_expired) state_nxt = S_IDLE;
            end
            S_CAPTURE: state_nxt = last_run ? S_FINISH : S_START;
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            go_q          <= 1'b0;
            rep_q         <= '0;
            pre_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            scope_trig    <= 1'b0;
            runs_done     <= '0;
            aes_key       <= '0;
            aes_plaintext <= '0;
            ct_out        <= '0;
        end else begin
            state <= state_nxt;
            go_q  <= go;
            case (state)
                S_LOAD: begin
                    aes_key       <= key_in;
                    aes_plaintext <= pt_in;
                    rep_q         <= repeat_cnt;
                    runs_done     <= '0;
                    pre_cnt       <= '0;
                    done          <= 1'b0;
                    timeout       <= 1'b0;
                    busy          <= 1'b1;
                    scope_trig    <= 1'b1;
                end
                S_PRE: pre_cnt <= pre_cnt + 4'd1;
                S_WAIT: begin
                    if (!done_seen && wd_expired) begin
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                        scope_trig <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    // Each result seeds the next encryption of the chain.
                    ct_out        <= aes_ciphertext;
                    aes_plaintext <= aes_ciphertext;
                    runs_done     <= runs_next[7:0];
                end
                S_FINISH: begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    scope_trig <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
